// File: rtl/rv32_pkg.sv
// Shared RV32IM decode definitions: opcodes, instruction formats,
// ID/EX control bundle and the immediate generator.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0 -- the field pattern a bubble presents downstream
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic illegal;
  } id_ex_ctrl_t;

  // Sign-extended immediate for each format; R and illegal carry no immediate.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'h000};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two asynchronous read ports with
// write-through bypass, one synchronous write port, x0 hardwired to zero.
module reg_file
  import rv32_pkg::*;
#(
  parameter  int DWIDTH   = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DWIDTH-1:0] o_rdata1,
  output logic [DWIDTH-1:0] o_rdata2
);

  logic [DWIDTH-1:0] r_regs [NUM_REGS];
  logic [DWIDTH-1:0] w_rdata1;
  logic [DWIDTH-1:0] w_rdata2;

  // Storage update: clear on reset, otherwise write any register except x0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DWIDTH{1'b0}};
      end
    end else if (i_we && (i_waddr != {AW{1'b0}})) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: x0 is zero, same-cycle writeback to the read index is forwarded.
  always_comb begin
    if (i_raddr1 == {AW{1'b0}}) begin
      w_rdata1 = {DWIDTH{1'b0}};
    end else if (i_we && (i_waddr == i_raddr1)) begin
      w_rdata1 = i_wdata;
    end else begin
      w_rdata1 = r_regs[i_raddr1];
    end
  end

  // Read port 2: same policy as port 1.
  always_comb begin
    if (i_raddr2 == {AW{1'b0}}) begin
      w_rdata2 = {DWIDTH{1'b0}};
    end else if (i_we && (i_waddr == i_raddr2)) begin
      w_rdata2 = i_wdata;
    end else begin
      w_rdata2 = r_regs[i_raddr2];
    end
  end

  assign o_rdata1 = w_rdata1;
  assign o_rdata2 = w_rdata2;

endmodule

// File: rtl/decode_pipe.sv
// RV32IM instruction-decode stage: decodes the fetched instruction, reads
// the register file, detects load-use hazards and registers the ID/EX boundary.
module decode_pipe
  import rv32_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [31:0]       pc_di,
  input  logic [31:0]       pc_plus_di,
  input  logic [31:0]       instruct_di,
  input  logic              flush_di,
  input  logic              ex_busy_di,
  input  logic              wb_en_di,
  input  logic [4:0]        wb_rd_di,
  input  logic [DWIDTH-1:0] wb_data_di,
  output logic              stall_do,
  output logic [31:0]       pc_do,
  output logic [31:0]       pc_plus_do,
  output logic [DWIDTH-1:0] rs1_data_do,
  output logic [DWIDTH-1:0] rs2_data_do,
  output logic [31:0]       imm_do,
  output logic [4:0]        rs1_do,
  output logic [4:0]        rs2_do,
  output logic [4:0]        rd_do,
  output logic [6:0]        opcode_do,
  output logic [2:0]        funct3_do,
  output logic [6:0]        funct7_do,
  output logic              reg_write_do,
  output logic              mem_read_do,
  output logic              mem_write_do,
  output logic              branch_do,
  output logic              jump_do,
  output logic              alu_src_do,
  output logic              illegal_do
);

  // Instruction fields
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_funct7;

  assign w_opcode = instruct_di[6:0];
  assign w_rd     = instruct_di[11:7];
  assign w_funct3 = instruct_di[14:12];
  assign w_rs1    = instruct_di[19:15];
  assign w_rs2    = instruct_di[24:20];
  assign w_funct7 = instruct_di[31:25];

  fmt_e              w_fmt;
  id_ex_ctrl_t       w_ctrl;
  logic [31:0]       w_imm;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_hazard;
  logic              w_stall;
  logic [DWIDTH-1:0] w_rs1_data;
  logic [DWIDTH-1:0] w_rs2_data;

  // ID/EX boundary registers
  logic [31:0]       r_pc;
  logic [31:0]       r_pc_plus;
  logic [DWIDTH-1:0] r_rs1_data;
  logic [DWIDTH-1:0] r_rs2_data;
  logic [31:0]       r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  id_ex_ctrl_t       r_ctrl;

  reg_file #(
    .DWIDTH   (DWIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .i_clk    (Clk_Core),
    .i_rst    (Rst_Core),
    .i_we     (wb_en_di),
    .i_waddr  (wb_rd_di),
    .i_wdata  (wb_data_di),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  // Main decoder: format and control bits from the opcode; unknown opcodes flag illegal only.
  always_comb begin
    w_fmt  = FMT_ILL;
    w_ctrl = 7'b000_0000;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_fmt            = FMT_U;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_JAL: begin
        w_fmt            = FMT_J;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_JALR: begin
        w_fmt            = FMT_I;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt         = FMT_B;
        w_ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        w_fmt            = FMT_I;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_STORE: begin
        w_fmt            = FMT_S;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_OPIMM: begin
        w_fmt            = FMT_I;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OPC_OP: begin
        w_fmt            = FMT_R;
        w_ctrl.reg_write = 1'b1;
      end
      default: begin
        w_fmt          = FMT_ILL;
        w_ctrl.illegal = 1'b1;
      end
    endcase
  end

  assign w_imm = imm_gen(instruct_di, w_fmt);

  // Source-register usage per format, used only for hazard qualification.
  always_comb begin
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_fmt)
      FMT_R, FMT_S, FMT_B: w_uses_rs2 = 1'b1;
      FMT_U, FMT_J:        w_uses_rs1 = 1'b0;
      default:             w_uses_rs2 = 1'b0;
    endcase
  end

  // Load-use hazard: the load now in ID/EX writes a register this instruction reads.
  always_comb begin
    if (r_ctrl.mem_read && (r_rd != 5'd0) &&
        ((w_uses_rs1 && (r_rd == w_rs1)) || (w_uses_rs2 && (r_rd == w_rs2)))) begin
      w_hazard = 1'b1;
    end else begin
      w_hazard = 1'b0;
    end
  end

  // Stall to fetch: busy freezes, flush overrides a hazard, reset forces it low.
  always_comb begin
    if (Rst_Core) begin
      w_stall = 1'b0;
    end else if (ex_busy_di) begin
      w_stall = 1'b1;
    end else if (flush_di) begin
      w_stall = 1'b0;
    end else begin
      w_stall = w_hazard;
    end
  end

  assign stall_do = w_stall;

  // ID/EX register: reset > busy hold > bubble (flush or hazard) > decoded instruction.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      r_pc       <= 32'h0000_0000;
      r_pc_plus  <= 32'h0000_0000;
      r_rs1_data <= {DWIDTH{1'b0}};
      r_rs2_data <= {DWIDTH{1'b0}};
      r_imm      <= 32'h0000_0000;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7   <= 7'd0;
      r_ctrl     <= 7'b000_0000;
    end else if (!ex_busy_di) begin
      r_pc      <= pc_di;
      r_pc_plus <= pc_plus_di;
      if (flush_di || w_hazard) begin
        r_rs1_data <= {DWIDTH{1'b0}};
        r_rs2_data <= {DWIDTH{1'b0}};
        r_imm      <= 32'h0000_0000;
        r_rs1      <= 5'd0;
        r_rs2      <= 5'd0;
        r_rd       <= 5'd0;
        r_opcode   <= INSTR_NOP[6:0];
        r_funct3   <= INSTR_NOP[14:12];
        r_funct7   <= INSTR_NOP[31:25];
        r_ctrl     <= 7'b000_0000;
      end else begin
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_imm      <= w_imm;
        r_rs1      <= w_rs1;
        r_rs2      <= w_rs2;
        r_rd       <= w_rd;
        r_opcode   <= w_opcode;
        r_funct3   <= w_funct3;
        r_funct7   <= w_funct7;
        r_ctrl     <= w_ctrl;
      end
    end
  end

  assign pc_do        = r_pc;
  assign pc_plus_do   = r_pc_plus;
  assign rs1_data_do  = r_rs1_data;
  assign rs2_data_do  = r_rs2_data;
  assign imm_do       = r_imm;
  assign rs1_do       = r_rs1;
  assign rs2_do       = r_rs2;
  assign rd_do        = r_rd;
  assign opcode_do    = r_opcode;
  assign funct3_do    = r_funct3;
  assign funct7_do    = r_funct7;
  assign reg_write_do = r_ctrl.reg_write;
  assign mem_read_do  = r_ctrl.mem_read;
  assign mem_write_do = r_ctrl.mem_write;
  assign branch_do    = r_ctrl.branch;
  assign jump_do      = r_ctrl.jump;
  assign alu_src_do   = r_ctrl.alu_src;
  assign illegal_do   = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: each stimulus cycle queues the expected
// stall and ID/EX contents; a monitor pops and compares once per clock.
module tb_decode_pipe;

  typedef struct {
    logic        stall;
    logic        c_ctrl; logic [6:0]  ctrl;
    logic        c_rd;   logic [4:0]  rd;
    logic        c_pc;   logic [31:0] pc;   logic [31:0] pcp;
    logic        c_imm;  logic [31:0] imm;
    logic        c_rs1;  logic [4:0]  rs1;
    logic        c_d1;   logic [31:0] d1;
    logic        c_d2;   logic [31:0] d2;
    logic        c_op;   logic [6:0]  op;
  } exp_t;

  // control vector order: reg_write mem_read mem_write branch jump alu_src illegal
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ADDI = 7'b1000010;
  localparam logic [6:0] C_R    = 7'b1000000;
  localparam logic [6:0] C_LW   = 7'b1100010;
  localparam logic [6:0] C_SW   = 7'b0010010;
  localparam logic [6:0] C_BR   = 7'b0001000;
  localparam logic [6:0] C_JAL  = 7'b1000110;
  localparam logic [6:0] C_ILL  = 7'b0000001;

  localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD3 = 32'h000101B3; // add x3,x2,x0
  localparam logic [31:0] I_ADD4 = 32'h00200233; // add x4,x0,x2
  localparam logic [31:0] I_ADD5 = 32'h000102B3; // add x5,x2,x0
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADDH = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_MUL  = 32'h022083B3; // mul x7,x1,x2
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] I_JAL  = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] I_ILL  = 32'h0000007F; // opcode 0x7F
  localparam logic [31:0] I_SW   = 32'hFE20AC23; // sw x2,-8(x1)
  localparam logic [31:0] I_LUI  = 32'h123451B7; // lui x3,0x12345

  logic        Clk_Core = 1'b0;
  logic        Rst_Core, flush_di, ex_busy_di, wb_en_di;
  logic [31:0] pc_di, pc_plus_di, instruct_di, wb_data_di;
  logic [4:0]  wb_rd_di;
  logic        stall_do;
  logic [31:0] pc_do, pc_plus_do, rs1_data_do, rs2_data_do, imm_do;
  logic [4:0]  rs1_do, rs2_do, rd_do;
  logic [6:0]  opcode_do, funct7_do;
  logic [2:0]  funct3_do;
  logic        reg_write_do, mem_read_do, mem_write_do, branch_do, jump_do, alu_src_do, illegal_do;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  decode_pipe dut (
    .Clk_Core(Clk_Core), .Rst_Core(Rst_Core),
    .pc_di(pc_di), .pc_plus_di(pc_plus_di), .instruct_di(instruct_di),
    .flush_di(flush_di), .ex_busy_di(ex_busy_di),
    .wb_en_di(wb_en_di), .wb_rd_di(wb_rd_di), .wb_data_di(wb_data_di),
    .stall_do(stall_do), .pc_do(pc_do), .pc_plus_do(pc_plus_do),
    .rs1_data_do(rs1_data_do), .rs2_data_do(rs2_data_do), .imm_do(imm_do),
    .rs1_do(rs1_do), .rs2_do(rs2_do), .rd_do(rd_do),
    .opcode_do(opcode_do), .funct3_do(funct3_do), .funct7_do(funct7_do),
    .reg_write_do(reg_write_do), .mem_read_do(mem_read_do), .mem_write_do(mem_write_do),
    .branch_do(branch_do), .jump_do(jump_do), .alu_src_do(alu_src_do), .illegal_do(illegal_do)
  );

  always #5 Clk_Core = ~Clk_Core;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic st, input logic [6:0] ctrl, input logic [4:0] rd,
                              input logic [31:0] pc);
    exp_t e;
    e = '{stall: st, c_ctrl: 1'b1, ctrl: ctrl, c_rd: 1'b1, rd: rd, c_pc: 1'b1, pc: pc,
          pcp: pc + 32'd4, c_imm: 1'b0, imm: 32'd0, c_rs1: 1'b0, rs1: 5'd0, c_d1: 1'b0,
          d1: 32'd0, c_d2: 1'b0, d2: 32'd0, c_op: 1'b0, op: 7'd0};
    return e;
  endfunction

  function automatic exp_t mk_rst();
    exp_t e;
    e = mk(1'b0, C_NONE, 5'd0, 32'd0);
    e.pcp = 32'd0;
    e.c_imm = 1'b1; e.c_rs1 = 1'b1; e.c_d1 = 1'b1; e.c_d2 = 1'b1; e.c_op = 1'b1;
    return e;
  endfunction

  // One fetch-side cycle: drive inputs at the falling edge and queue the expectation.
  task automatic cyc(input logic rst, input logic fl, input logic busy, input logic [31:0] pc,
                     input logic [31:0] ins, input logic wen, input logic [4:0] wrd,
                     input logic [31:0] wdat, input exp_t e);
    @(negedge Clk_Core);
    Rst_Core = rst; flush_di = fl; ex_busy_di = busy;
    pc_di = pc; pc_plus_di = pc + 32'd4; instruct_di = ins;
    wb_en_di = wen; wb_rd_di = wrd; wb_data_di = wdat;
    q.push_back(e);
  endtask

  // Monitor: stall sampled just before the edge, registered outputs just after.
  initial begin
    exp_t e;
    logic st_s;
    forever begin
      @(negedge Clk_Core);
      #4;
      st_s = stall_do;
      @(posedge Clk_Core);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {31'd0, st_s}, {31'd0, e.stall});
        if (e.c_ctrl) chk("ctrl", {25'd0, reg_write_do, mem_read_do, mem_write_do, branch_do,
                                   jump_do, alu_src_do, illegal_do}, {25'd0, e.ctrl});
        if (e.c_rd)  chk("rd", {27'd0, rd_do}, {27'd0, e.rd});
        if (e.c_pc) begin
          chk("pc", pc_do, e.pc);
          chk("pc_plus", pc_plus_do, e.pcp);
        end
        if (e.c_imm) chk("imm", imm_do, e.imm);
        if (e.c_rs1) chk("rs1", {27'd0, rs1_do}, {27'd0, e.rs1});
        if (e.c_d1)  chk("rs1_data", rs1_data_do, e.d1);
        if (e.c_d2)  chk("rs2_data", rs2_data_do, e.d2);
        if (e.c_op)  chk("opcode", {25'd0, opcode_do}, {25'd0, e.op});
      end
    end
  end

  initial begin
    exp_t e;
    // reset held two cycles with a live instruction on the input
    e = mk_rst();
    cyc(1'b1, 1'b0, 1'b0, 32'h100, I_ADDI, 1'b0, 5'd0, 32'd0, e);
    cyc(1'b1, 1'b0, 1'b0, 32'h100, I_ADDI, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_ADDI, 5'd1, 32'h100); e.c_imm = 1'b1; e.imm = 32'd5;
    cyc(1'b0, 1'b0, 1'b0, 32'h100, I_ADDI, 1'b0, 5'd0, 32'd0, e);
    // regfile bypass, x0 write ignored, stored value readback
    e = mk(1'b0, C_R, 5'd3, 32'h104); e.c_rs1 = 1'b1; e.rs1 = 5'd2; e.c_d1 = 1'b1; e.d1 = 32'hDEADBEEF;
    cyc(1'b0, 1'b0, 1'b0, 32'h104, I_ADD3, 1'b1, 5'd2, 32'hDEADBEEF, e);
    e = mk(1'b0, C_R, 5'd4, 32'h108); e.c_d1 = 1'b1; e.d1 = 32'd0; e.c_d2 = 1'b1; e.d2 = 32'hDEADBEEF;
    cyc(1'b0, 1'b0, 1'b0, 32'h108, I_ADD4, 1'b1, 5'd0, 32'h12345678, e);
    e = mk(1'b0, C_R, 5'd5, 32'h10C); e.c_d1 = 1'b1; e.d1 = 32'hDEADBEEF; e.c_d2 = 1'b1; e.d2 = 32'd0;
    cyc(1'b0, 1'b0, 1'b0, 32'h10C, I_ADD5, 1'b0, 5'd0, 32'd0, e);
    // load-use: one stall cycle with a bubble, then the add issues
    e = mk(1'b0, C_LW, 5'd5, 32'h200);
    cyc(1'b0, 1'b0, 1'b0, 32'h200, I_LW, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b1, C_NONE, 5'd0, 32'h204); e.c_op = 1'b1; e.op = 7'h13;
    cyc(1'b0, 1'b0, 1'b0, 32'h204, I_ADDH, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_R, 5'd6, 32'h204); e.c_rs1 = 1'b1; e.rs1 = 5'd5;
    cyc(1'b0, 1'b0, 1'b0, 32'h204, I_ADDH, 1'b0, 5'd0, 32'd0, e);
    // flush in the hazard cycle: no stall, bubble, redirect target follows
    e = mk(1'b0, C_LW, 5'd5, 32'h300);
    cyc(1'b0, 1'b0, 1'b0, 32'h300, I_LW, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_NONE, 5'd0, 32'h304);
    cyc(1'b0, 1'b1, 1'b0, 32'h304, I_ADDH, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_ADDI, 5'd1, 32'h400);
    cyc(1'b0, 1'b0, 1'b0, 32'h400, I_ADDI, 1'b0, 5'd0, 32'd0, e);
    // busy hold for three cycles while mul sits in ID/EX
    e = mk(1'b0, C_R, 5'd7, 32'h404); e.c_rs1 = 1'b1; e.rs1 = 5'd1;
    cyc(1'b0, 1'b0, 1'b0, 32'h404, I_MUL, 1'b0, 5'd0, 32'd0, e);
    e.stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'h408, I_ADDI, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_ADDI, 5'd1, 32'h408);
    cyc(1'b0, 1'b0, 1'b0, 32'h408, I_ADDI, 1'b0, 5'd0, 32'd0, e);
    // busy and flush together: busy wins; flush applies once busy drops
    e = mk(1'b1, C_ADDI, 5'd1, 32'h408);
    cyc(1'b0, 1'b1, 1'b1, 32'h40C, I_ADD3, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_NONE, 5'd0, 32'h40C);
    cyc(1'b0, 1'b1, 1'b0, 32'h40C, I_ADD3, 1'b0, 5'd0, 32'd0, e);
    // immediates and illegal opcode
    e = mk(1'b0, C_BR, 5'd0, 32'h500); e.c_rd = 1'b0; e.c_imm = 1'b1; e.imm = 32'hFFFFFFFC;
    cyc(1'b0, 1'b0, 1'b0, 32'h500, I_BEQ, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_JAL, 5'd1, 32'h504); e.c_imm = 1'b1; e.imm = 32'h00000800;
    cyc(1'b0, 1'b0, 1'b0, 32'h504, I_JAL, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_ILL, 5'd0, 32'h508); e.c_imm = 1'b1; e.imm = 32'd0;
    cyc(1'b0, 1'b0, 1'b0, 32'h508, I_ILL, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_SW, 5'd0, 32'h50C); e.c_rd = 1'b0; e.c_imm = 1'b1; e.imm = 32'hFFFFFFF8;
    cyc(1'b0, 1'b0, 1'b0, 32'h50C, I_SW, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_ADDI, 5'd3, 32'h510); e.c_imm = 1'b1; e.imm = 32'h12345000;
    cyc(1'b0, 1'b0, 1'b0, 32'h510, I_LUI, 1'b0, 5'd0, 32'd0, e);
    // reset arriving in a would-be stall cycle
    e = mk(1'b0, C_LW, 5'd5, 32'h600);
    cyc(1'b0, 1'b0, 1'b0, 32'h600, I_LW, 1'b0, 5'd0, 32'd0, e);
    e = mk_rst();
    cyc(1'b1, 1'b0, 1'b0, 32'h604, I_ADDH, 1'b0, 5'd0, 32'd0, e);
    e = mk(1'b0, C_R, 5'd6, 32'h604);
    cyc(1'b0, 1'b0, 1'b0, 32'h604, I_ADDH, 1'b0, 5'd0, 32'd0, e);
    // drain the scoreboard
    @(negedge Clk_Core);
    @(negedge Clk_Core);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
